// File: rtl/sevenseg_scan_decoder.sv
// Observer for a multiplexed active-low seven-segment bus: synchronises the
// bus, waits for a stable window, and decodes the addressed digit's glyph.
module sevenseg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [6:0]              segment,
    input  logic [NUM_DIGITS-1:0]   anode,
    output logic [4*NUM_DIGITS-1:0] hexValues,
    output logic [NUM_DIGITS-1:0]   digitValid,
    output logic                    updateStrobe,
    output logic                    patternError,
    output logic                    anodeError
);

    localparam int SW = NUM_DIGITS + 7;

    localparam logic [0:0] SETTLE = 1'b0;
    localparam logic [0:0] HELD   = 1'b1;

    logic [SW-1:0]         sync1, sync2, prev;
    logic [7:0]            cnt;
    logic [0:0]            state;
    logic                  same;
    logic                  capture;
    logic [NUM_DIGITS-1:0] s_anode;
    logic [6:0]            pattern;
    logic [3:0]            n_low;
    logic [4:0]            dec;

    // Active-high {A..G} pattern to {hit, nibble}
    function automatic logic [4:0] glyph_decode(input logic [6:0] p);
        case (p)
            7'h7E: glyph_decode = 5'h10;
            7'h30: glyph_decode = 5'h11;
            7'h6D: glyph_decode = 5'h12;
            7'h79: glyph_decode = 5'h13;
            7'h33: glyph_decode = 5'h14;
            7'h5B: glyph_decode = 5'h15;
            7'h5F: glyph_decode = 5'h16;
            7'h70: glyph_decode = 5'h17;
            7'h7F: glyph_decode = 5'h18;
            7'h73: glyph_decode = 5'h19;
            7'h77: glyph_decode = 5'h1A;
            7'h1F: glyph_decode = 5'h1B;
            7'h0D: glyph_decode = 5'h1C;
            7'h3D: glyph_decode = 5'h1D;
            7'h4F: glyph_decode = 5'h1E;
            7'h47: glyph_decode = 5'h1F;
            default: glyph_decode = 5'h00;
        endcase
    endfunction

    assign same    = (sync2 == prev);
    assign capture = (state == SETTLE) && same && (cnt == 8'(STABLE_CYCLES - 1));
    assign s_anode = sync2[SW-1:7];
    assign pattern = ~sync2[6:0];
    assign dec     = glyph_decode(pattern);

    always_comb begin
        n_low = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!s_anode[i]) n_low = n_low + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
            cnt   <= '0;
            state <= SETTLE;
        end else begin
            sync1 <= {anode, segment};
            sync2 <= sync1;
            prev  <= sync2;
            if (!same) begin
                cnt   <= '0;
                state <= SETTLE;
            end else begin
                if (cnt != 8'(STABLE_CYCLES)) cnt <= cnt + 8'd1;
                if (capture) state <= HELD;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hexValues    <= '0;
            digitValid   <= '0;
            updateStrobe <= 1'b0;
            patternError <= 1'b0;
            anodeError   <= 1'b0;
        end else begin
            updateStrobe <= capture && (n_low == 4'd1) && dec[4];
            patternError <= capture && (n_low == 4'd1) && !dec[4] && (pattern != 7'h00);
            anodeError   <= capture && (n_low > 4'd1);
            // Only the single addressed slot is touched; others are left alone
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (capture && (n_low == 4'd1) && !s_anode[i]) begin
                    if (dec[4]) begin
                        hexValues[4*i +: 4] <= dec[3:0];
                        digitValid[i]       <= 1'b1;
                    end else begin
                        digitValid[i]       <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder: each presented stable pattern
// pushes its expected pulse; a negedge monitor pops and compares.
module tb_sevenseg_scan_decoder;

    logic        clk;
    logic        resetN;
    logic [6:0]  segment;
    logic [3:0]  anode;
    logic [15:0] hexValues;
    logic [3:0]  digitValid;
    logic        updateStrobe;
    logic        patternError;
    logic        anodeError;

    sevenseg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .resetN(resetN), .segment(segment), .anode(anode),
        .hexValues(hexValues), .digitValid(digitValid),
        .updateStrobe(updateStrobe), .patternError(patternError),
        .anodeError(anodeError)
    );

    typedef struct {
        int          kind;   // 1 strobe, 2 pattern error, 3 anode error
        logic [15:0] hex;
        logic [3:0]  valid;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_strobe = 0;
    logic [15:0] m_hex;
    logic [3:0]  m_valid;
    logic [10:0] last;
    logic [6:0]  glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h73, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bench model of one capture of a pattern first sampled at the next edge
    task automatic expect_capture(input logic [3:0] an, input logic [6:0] p);
        int   zeros = 0;
        int   idx = 0;
        int   hit = -1;
        exp_t e;
        last = {an, ~p};
        for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; idx = i; end
        for (int v = 0; v < 16; v++) if (glyph[v] == p) hit = v;
        e.kind = 0;
        if (zeros > 1) e.kind = 3;
        else if (zeros == 1) begin
            if (hit >= 0) begin
                m_hex[4*idx +: 4] = 4'(hit);
                m_valid[idx] = 1'b1;
                e.kind = 1;
            end else begin
                m_valid[idx] = 1'b0;
                if (p != 7'h00) e.kind = 2;
            end
        end
        e.hex = m_hex; e.valid = m_valid; e.cyc = cyc + 7;
        if (e.kind != 0) q.push_back(e);
    endtask

    task automatic present(input logic [3:0] an, input logic [6:0] p, input int hold);
        anode = an;
        segment = ~p;
        if (hold >= 5 && {an, ~p} != last) expect_capture(an, p);
        else last = {an, ~p};
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, " hex"}, 32'(hexValues), 32'(m_hex));
        check({tag, " valid"}, 32'(digitValid), 32'(m_valid));
        check({tag, " pending"}, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (resetN && (updateStrobe || patternError || anodeError)) begin
            int   k;
            exp_t e;
            k = updateStrobe ? 1 : (patternError ? 2 : 3);
            if (updateStrobe) n_strobe++;
            check("pulse onehot", 32'(updateStrobe) + 32'(patternError) + 32'(anodeError), 1);
            if (q.size() == 0) check("unexpected pulse kind", k, 0);
            else begin
                e = q.pop_front();
                check("pulse kind", k, e.kind);
                check("pulse cycle", cyc, e.cyc);
                check("pulse hex", 32'(hexValues), 32'(e.hex));
                check("pulse valid", 32'(digitValid), 32'(e.valid));
            end
        end
    end

    initial begin
        int s0;
        resetN = 1'b0;
        anode = '1;
        segment = '1;
        m_hex = '0;
        m_valid = '0;
        last = '1;
        #1;
        check("reset hex", 32'(hexValues), 0);
        check("reset valid", 32'(digitValid), 0);
        check("reset pulses", {updateStrobe, patternError, anodeError}, 0);
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;

        // Single digit, held
        present(4'b1110, 7'h6D, 10);
        check("t1 hex0", 32'(hexValues[3:0]), 2);
        check_state("t1");

        // Scan 1,A,C,F over four digits, twice
        s0 = n_strobe;
        for (int r = 0; r < 2; r++) begin
            present(4'b1110, glyph[1], 8);
            present(4'b1101, glyph[10], 8);
            present(4'b1011, glyph[12], 8);
            present(4'b0111, glyph[15], 8);
        end
        check("scan hex", 32'(hexValues), 32'h0000FCA1);
        check("scan valid", 32'(digitValid), 32'hF);
        check("scan strobes", n_strobe - s0, 8);
        check_state("scan");

        // Every glyph on digit 3
        for (int v = 0; v < 16; v++) present(4'b0111, glyph[v], 8);
        check_state("glyphs");

        // Glitchy segments never settle
        for (int g = 0; g < 10; g++) present(4'b1101, glyph[3 + (g % 2)], 2);
        present(4'b1111, 7'h00, 8);
        check_state("glitch");

        // Pattern error and dark digit
        present(4'b1011, glyph[5], 8);
        present(4'b1011, 7'h01, 8);
        check("perr hex2", 32'(hexValues[11:8]), 5);
        check("perr valid2", 32'(digitValid[2]), 0);
        present(4'b1110, 7'h00, 8);
        check_state("dark");

        // Multiple anodes, then blanking
        present(4'b1001, glyph[8], 8);
        present(4'b1111, 7'h00, 8);
        check_state("anode");

        // Reset in the middle of a stable window
        present(4'b1101, glyph[9], 8);
        check_state("pre-reset");
        anode = 4'b1101;
        segment = ~glyph[7];
        last = {anode, segment};
        repeat (3) @(posedge clk);
        #4;
        resetN = 1'b0;
        #1;
        check("midreset hex", 32'(hexValues), 0);
        check("midreset valid", 32'(digitValid), 0);
        check("midreset pulses", {updateStrobe, patternError, anodeError}, 0);
        m_hex = '0;
        m_valid = '0;
        last = '1;
        repeat (2) @(posedge clk);
        #4;
        resetN = 1'b1;
        expect_capture(4'b1101, glyph[7]);
        repeat (8) @(posedge clk);
        #1;
        check("post-reset hex1", 32'(hexValues[7:4]), 7);
        check_state("post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
